// File: rtl/key_cond_pkg.sv
// rtl/key_cond_pkg.sv - shared types and constants for the key conditioner
package key_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } key_state_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one key channel: synchronizer, polarity fix, debounce FSM, pulse/level
module debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic confirm,
    output logic pulse,
    output logic level
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  pressed;
    key_state_e            state, state_d;
    logic [CW-1:0]         cnt, cnt_d;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_DEPTH{RELEASED}};
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], key_raw};
        end
    end

    assign pressed = sync_q[SYNC_DEPTH-1] ^ RELEASED;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        confirm = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt == TERM) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    confirm = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_REL_WAIT: begin
                // Re-press during release window returns to HELD silently: no repeat pulse.
                if (pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt == TERM) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pulse <= confirm;
        end
    end

    assign level = (state == ST_HELD) || (state == ST_REL_WAIT);

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - two debounced keys plus switch bank captured on key 1 press
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1_raw,
    input  logic       key2_raw,
    input  logic [3:0] sw_raw,
    output logic       key1_pulse,
    output logic       key2_pulse,
    output logic       key1_level,
    output logic       key2_level,
    output logic [3:0] sw_q
);

    logic                        key1_confirm;
    logic                        unused_key2_confirm;
    logic [SYNC_DEPTH-1:0][3:0]  sw_sync;

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key1 (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key1_raw),
        .confirm (key1_confirm),
        .pulse   (key1_pulse),
        .level   (key1_level)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key2 (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key2_raw),
        .confirm (unused_key2_confirm),
        .pulse   (key2_pulse),
        .level   (key2_level)
    );

    // Capture shares the pulse's edge so slot/value are valid alongside key1_pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync <= '0;
            sw_q    <= '0;
        end else begin
            sw_sync <= {sw_sync[SYNC_DEPTH-2:0], sw_raw};
            if (key1_confirm) begin
                sw_q <= sw_sync[SYNC_DEPTH-1];
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized and directed self-checking bench for key_conditioner
module tb_key_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key1_raw = 1'b1;
    logic       key2_raw = 1'b1;
    logic [3:0] sw_raw = 4'd0;
    logic       key1_pulse, key2_pulse, key1_level, key2_level;
    logic [3:0] sw_q;

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key1_raw   (key1_raw),
        .key2_raw   (key2_raw),
        .sw_raw     (sw_raw),
        .key1_pulse (key1_pulse),
        .key2_pulse (key2_pulse),
        .key1_level (key1_level),
        .key2_level (key2_level),
        .sw_q       (sw_q)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a key's debounced level flips once the pressed value seen after the
    // synchronizer has held the opposite value for D+1 consecutive edges.
    logic       m_s1 [2];
    logic       m_s2 [2];
    logic       m_cur [2];
    logic       m_level [2];
    logic       m_pulse [2];
    int         m_run [2];
    logic [3:0] m_sws1, m_sws2, m_swq;
    logic       m_raw [2];
    logic       m_p, m_conf1;
    bit         m_ready = 1'b0;

    always @(posedge clk) begin
        m_raw[0] = key1_raw;
        m_raw[1] = key2_raw;
        m_conf1  = 1'b0;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b1; m_s2[k] = 1'b1;
                m_cur[k] = 1'b0; m_run[k] = 0;
                m_level[k] = 1'b0; m_pulse[k] = 1'b0;
            end
            m_sws1 = 4'd0; m_sws2 = 4'd0; m_swq = 4'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_p = !m_s2[k];
                if (m_p == m_cur[k]) m_run[k]++;
                else begin m_cur[k] = m_p; m_run[k] = 1; end
                m_pulse[k] = 1'b0;
                if (m_cur[k] != m_level[k] && m_run[k] >= D + 1) begin
                    m_level[k] = m_cur[k];
                    m_pulse[k] = m_cur[k];
                    if (k == 0) m_conf1 = m_cur[k];
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = m_raw[k];
            end
            if (m_conf1) m_swq = m_sws2;
            m_sws2 = m_sws1;
            m_sws1 = sw_raw;
        end
        m_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("key1_pulse", 32'(key1_pulse), 32'(m_pulse[0]));
            chk("key2_pulse", 32'(key2_pulse), 32'(m_pulse[1]));
            chk("key1_level", 32'(key1_level), 32'(m_level[0]));
            chk("key2_level", 32'(key2_level), 32'(m_level[1]));
            chk("sw_q", 32'(sw_q), 32'(m_swq));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int pulses, drops, h1, h2;

    initial begin
        step(); step();
        chk("reset_key1_pulse", 32'(key1_pulse), 32'd0);
        chk("reset_key1_level", 32'(key1_level), 32'd0);
        chk("reset_key2_level", 32'(key2_level), 32'd0);
        chk("reset_sw_q", 32'(sw_q), 32'd0);
        rst = 1'b0;
        repeat (3) step();

        sw_raw = 4'b1011; key1_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("clean_pulse", 32'(key1_pulse), 32'(e == 7));
            chk("clean_level", 32'(key1_level), 32'(e >= 7));
            if (e == 7) begin
                chk("clean_sw_q", 32'(sw_q), 32'hB);
                chk("model_clean_pulse", 32'(m_pulse[0]), 32'd1);
            end
        end
        key1_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("release_level", 32'(key1_level), 32'(e < 7));
        end
        repeat (4) step();

        key2_raw = 1'b0; step();
        key2_raw = 1'b1; step();
        key2_raw = 1'b0; step();
        key2_raw = 1'b1; step();
        key2_raw = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk("bounce_pulse", 32'(key2_pulse), 32'(e == 7));
        end
        key2_raw = 1'b1;
        repeat (10) step();

        key1_raw = 1'b0; pulses = 0; drops = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(key1_pulse);
            if (i >= 6 && !key1_level) drops++;
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_level", 32'(drops), 32'd0);

        key1_raw = 1'b1; pulses = 0; drops = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) key1_raw = 1'b0;
            step();
            pulses += int'(key1_pulse);
            if (!key1_level) drops++;
        end
        chk("glitch_pulses", 32'(pulses), 32'd0);
        chk("glitch_level", 32'(drops), 32'd0);
        chk("model_glitch_level", 32'(m_level[0]), 32'd1);
        key1_raw = 1'b1;
        repeat (10) step();

        sw_raw = 4'b0110; key1_raw = 1'b0; key2_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("simul_pulse1", 32'(key1_pulse), 32'(e == 7));
            chk("simul_pulse2", 32'(key2_pulse), 32'(e == 7));
            if (e == 7) chk("simul_sw_q", 32'(sw_q), 32'h6);
        end
        key1_raw = 1'b1; key2_raw = 1'b1;
        repeat (10) step();

        sw_raw = 4'b1001; key1_raw = 1'b0;
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_sw_q", 32'(sw_q), 32'd0);
        chk("rst_level", 32'(key1_level), 32'd0);
        for (int e = 1; e <= 9; e++) begin
            step();
            chk("rst_pulse", 32'(key1_pulse), 32'(e == 7));
            chk("rst_sw_q_hold", 32'(sw_q), (e < 7) ? 32'd0 : 32'h9);
        end
        key1_raw = 1'b1;
        repeat (10) step();

        h1 = 0; h2 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (h1 == 0) begin key1_raw = 1'($urandom); h1 = $urandom_range(1, 12); end
            if (h2 == 0) begin key2_raw = 1'($urandom); h2 = $urandom_range(1, 12); end
            h1--; h2--;
            if ($urandom_range(0, 5) == 0) sw_raw = 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; key1_raw = 1'b1; key2_raw = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
